// File: rtl/resta_serie_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
interface resta_serie_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bout;

  modport master (output start, a, b, input busy, done, d, bout);
  modport slave  (input start, a, b, output busy, done, d, bout);
endinterface

// File: rtl/resta_serie.sv
// Bit-serial WIDTH-bit subtractor d = a - b, LSB first, one borrow flip-flop.
module resta_serie #(
  parameter int unsigned WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  resta_serie_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] ra, rb, acc, d_r;
  logic             br, bout_r;
  logic [CW-1:0]    cnt;
  logic             ai, bi, diff, br_nx, last;

  always_comb begin
    ai       = ra[0];
    bi       = rb[0];
    diff     = ai ^ bi ^ br;
    br_nx    = (~ai & bi) | (~(ai ^ bi) & br);
    last     = (cnt == CW'(WIDTH - 1));
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = SHIFT;
      SHIFT:   if (last)      state_nx = FIN;
      FIN:                    state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      ra     <= '0;
      rb     <= '0;
      acc    <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      d_r    <= '0;
      bout_r <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (bus.start) begin
          ra  <= bus.a;
          rb  <= bus.b;
          acc <= '0;
          br  <= 1'b0;
          cnt <= '0;
        end
        SHIFT: begin
          // Diff bits enter at the MSB so bit 0 lands at the LSB after WIDTH shifts.
          acc <= {diff, acc[WIDTH-1:1]};
          ra  <= ra >> 1;
          rb  <= rb >> 1;
          br  <= br_nx;
          cnt <= cnt + 1'b1;
          if (last) begin
            d_r    <= {diff, acc[WIDTH-1:1]};
            bout_r <= br_nx;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state == SHIFT);
  assign bus.done = (state == FIN);
  assign bus.d    = d_r;
  assign bus.bout = bout_r;
endmodule

// File: tb/tb_resta_serie.sv
// Randomized and directed checks of resta_serie at WIDTH=4 and WIDTH=8.
module tb_resta_serie;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   ncmp = 0;
  int   nfail = 0;

  always #5 clk = ~clk;

  resta_serie_if #(.WIDTH(4)) f4 ();
  resta_serie_if #(.WIDTH(8)) f8 ();

  resta_serie #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(f4));
  resta_serie #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(f8));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic s, input int a, input int b);
    if (w == 4) begin
      f4.start = s; f4.a = a[3:0]; f4.b = b[3:0];
    end else begin
      f8.start = s; f8.a = a[7:0]; f8.b = b[7:0];
    end
  endtask

  task automatic sample(input int w, output logic bz, output logic dn,
                        output logic [31:0] dd, output logic bo);
    if (w == 4) begin
      bz = f4.busy; dn = f4.done; dd = 32'(f4.d); bo = f4.bout;
    end else begin
      bz = f8.busy; dn = f8.done; dd = 32'(f8.d); bo = f8.bout;
    end
  endtask

  // Reference: result is (a-b) mod 2^w, borrow is a<b; done exactly w edges after accept.
  task automatic op(input int w, input int a, input int b, input bit noise);
    int          mask;
    logic [31:0] de, dprev, dd;
    logic        be, bz, dn, bo;
    mask = (1 << w) - 1;
    de   = 32'((a - b) & mask);
    be   = (a < b);
    sample(w, bz, dn, dprev, bo);
    drive(w, 1'b1, a, b);
    tick();
    for (int i = 1; i <= w; i++) begin
      if (noise) drive(w, 1'($urandom_range(0, 1)), int'($urandom) & mask, int'($urandom) & mask);
      else       drive(w, 1'b0, a, b);
      sample(w, bz, dn, dd, bo);
      chk("busy_shift", 32'(bz), 32'd1);
      chk("done_shift", 32'(dn), 32'd0);
      chk("d_hold_shift", dd, dprev);
      tick();
    end
    sample(w, bz, dn, dd, bo);
    chk("done_pulse", 32'(dn), 32'd1);
    chk("busy_fin", 32'(bz), 32'd0);
    chk("d_result", dd, de);
    chk("bout_result", 32'(bo), 32'(be));
    drive(w, noise, a, b);
    tick();
    drive(w, 1'b0, 0, 0);
    sample(w, bz, dn, dd, bo);
    chk("busy_idle", 32'(bz), 32'd0);
    chk("done_clear", 32'(dn), 32'd0);
    chk("d_hold_idle", dd, de);
    chk("bout_hold_idle", 32'(bo), 32'(be));
  endtask

  initial begin
    logic        bz, dn, bo;
    logic [31:0] dd;
    int          last_done, ndone, ra, rbv;

    drive(4, 1'b0, 0, 0);
    drive(8, 1'b1, 8'hAA, 8'h55);
    tick();
    tick();
    sample(4, bz, dn, dd, bo);
    chk("rst_busy4", 32'(bz), 32'd0);
    chk("rst_done4", 32'(dn), 32'd0);
    chk("rst_d4", dd, 32'd0);
    chk("rst_bout4", 32'(bo), 32'd0);
    sample(8, bz, dn, dd, bo);
    chk("rst_busy8", 32'(bz), 32'd0);
    chk("rst_d8", dd, 32'd0);
    drive(8, 1'b0, 0, 0);
    rst_n = 1'b1;
    tick();

    op(4, 7, 3, 1'b0);
    op(4, 3, 7, 1'b0);
    op(4, 0, 1, 1'b0);
    op(4, 15, 15, 1'b0);
    op(4, 7, 3, 1'b1);
    op(4, 9, 2, 1'b0);

    // Reset in the second SHIFT cycle aborts the operation.
    drive(4, 1'b1, 8, 1);
    tick();
    drive(4, 1'b0, 8, 1);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sample(4, bz, dn, dd, bo);
    chk("abort_busy", 32'(bz), 32'd0);
    chk("abort_done", 32'(dn), 32'd0);
    chk("abort_d", dd, 32'd0);
    chk("abort_bout", 32'(bo), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      sample(4, bz, dn, dd, bo);
      chk("abort_no_done", 32'(dn), 32'd0);
    end
    op(4, 8, 1, 1'b0);

    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        op(4, x, y, (((x + y) % 5) == 0));

    for (int i = 0; i < 40; i++)
      op(8, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b1);
    op(8, 0, 255, 1'b0);
    op(8, 255, 0, 1'b0);

    // Start held high: one result every WIDTH+2 cycles.
    ra = int'($urandom_range(0, 15));
    rbv = int'($urandom_range(0, 15));
    drive(4, 1'b1, ra, rbv);
    last_done = -1;
    ndone = 0;
    for (int c = 1; c <= 36; c++) begin
      tick();
      sample(4, bz, dn, dd, bo);
      chk("held_no_overlap", 32'(bz & dn), 32'd0);
      if (dn) begin
        ndone++;
        chk("held_d", dd, 32'((ra - rbv) & 15));
        chk("held_bout", 32'(bo), 32'(ra < rbv));
        if (last_done >= 0) chk("held_period", 32'(c - last_done), 32'd6);
        last_done = c;
      end
    end
    chk("held_count", 32'(ndone), 32'd6);
    drive(4, 1'b0, 0, 0);
    for (int i = 0; i < 8; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/resta_serie.md
Name: resta_serie

Overview:
- Bit-serial WIDTH-bit subtractor: computes d = a - b, one bit per clock, LSB first, using a single borrow flip-flop.
- Performs the inverse operation of the combinational 4-bit full-adder chain.
- Sits beside that adder as the area-cheap sequential datapath element.
- Driven by a start/busy/done handshake from a controller or testbench.

Parameters:
- WIDTH, 4, operand and result width in bits (legal values are 2 or more).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- start  input  1  request pulse; accepted only in IDLE.
- a  input  WIDTH  minuend, sampled on the accepting edge.
- b  input  WIDTH  subtrahend, sampled on the accepting edge.
- busy  output  1  high while the subtraction is in progress (SHIFT state).
- done  output  1  one-cycle pulse; d and bout are valid from this cycle on.
- d  output  WIDTH  difference (a - b) mod 2^WIDTH.
- bout  output  1  final borrow; 1 when a < b, unsigned.

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE, busy=0, done=0, d=0, bout=0, internal shift registers, borrow and bit counter all cleared. Reset overrides start and any operation in progress.
- States: IDLE, SHIFT, FIN.
- IDLE, start=1 at edge k:
  - latch a into ra and b into rb;
  - clear borrow and the working result register;
  - set count=0;
  - go to SHIFT; busy=1 from edge k.
- IDLE, start=0: stay in IDLE. Outputs hold.
- SHIFT, per edge:
  - ai=ra[0], bi=rb[0];
  - diff bit = ai ^ bi ^ br;
  - br_next = (~ai & bi) | (~(ai ^ bi) & br);
  - shift diff bit into the MSB of the working register;
  - shift ra and rb right by 1;
  - count++.
- SHIFT exit: on the edge processing bit WIDTH-1 (edge k+WIDTH):
  - copy working register to d and br_next to bout;
  - set done=1, busy=0;
  - go to FIN.
- FIN: next edge clears done and returns to IDLE. start is ignored in FIN.
- Latency:
  - done rises exactly WIDTH edges after the start-accepting edge;
  - busy is high for exactly WIDTH cycles;
  - back-to-back throughput is one result per WIDTH+2 cycles.
- start while busy or in FIN: ignored, no queuing.
- a and b may change freely after the accepting edge; the result uses the latched values only.
- d and bout change only on the edge that asserts done. Partial results are never visible on d, and they hold their last value indefinitely, including through later IDLE cycles.
- Counter width: clog2(WIDTH)+1 bits. The counter must not wrap before the termination compare.
- Arithmetic is unsigned modulo 2^WIDTH. bout=1 iff a<b. a==b gives d=0, bout=0.
- Reset mid-SHIFT: the operation is aborted, d=0, bout=0, done is never pulsed for the aborted operation.

Test Plan:
- WIDTH=4, a=0111, b=0011, start 1 cycle -> busy high 4 cycles; done pulse at 4th edge after start; d=0100, bout=0.
- a=0011, b=0111 -> d=1100, bout=1. a=0000, b=0001 -> d=1111, bout=1. a=1111, b=1111 -> d=0000, bout=0.
- Change a and b every cycle during SHIFT; pulse start again while busy=1 and in FIN -> first result unaffected (0111-0011=0100), no second done pulse; start in the next IDLE then yields a new correct result.
- Drive rst_n=0 for 1 edge at the 2nd SHIFT cycle of 1000-0001 -> busy=0, done stays 0, d=0000, bout=0; a fresh start afterwards returns 0111 with bout=0.
- Exhaustive check over all 256 (a,b) pairs at WIDTH=4 against a reference model -> d==(a-b)&4'hF and bout==(a<b) for every done pulse. Repeat a random sample at WIDTH=8.
- Hold start=1 continuously -> an operation is accepted in every IDLE, done pulses every 6 cycles, busy never overlaps done.
